// File: rtl/simple_dram_responder_pkg.sv
`default_nettype none
// ============================================================================
// simple_dram_responder_pkg : SimpleDRAM MemReq/MemResp types, line geometry
// Rev 1.0
// ============================================================================
package simple_dram_responder_pkg;

  localparam int SIMPLE_DRAM_LINE_BYTES = 64;
  localparam int SIMPLE_DRAM_DEPTH      = 1024;
  localparam int SIMPLE_DRAM_DATA_W     = SIMPLE_DRAM_LINE_BYTES * 8;

  typedef struct packed {
    logic        valid;
    logic        isWrite;
    logic [63:0] addr;
    logic [SIMPLE_DRAM_DATA_W-1:0] data;
  } MemReq;

  typedef struct packed {
    logic        valid;
    logic [SIMPLE_DRAM_DATA_W-1:0] data;
  } MemResp;

endpackage
`default_nettype wire

// File: rtl/simple_dram_responder_if.sv
`default_nettype none
// ============================================================================
// simple_dram_responder_if : SimpleDRAM request/response channel bundle
// Rev 1.0
// ============================================================================
interface simple_dram_responder_if;
  import simple_dram_responder_pkg::*;

  MemReq  req_in;
  logic   req_grant_out;
  MemResp resp_out;
  logic   resp_grant_in;

  modport master (
    output req_in,
    output resp_grant_in,
    input  req_grant_out,
    input  resp_out
  );

  modport slave (
    input  req_in,
    input  resp_grant_in,
    output req_grant_out,
    output resp_out
  );

endinterface
`default_nettype wire

// File: rtl/simple_dram_resp_fifo.sv
`default_nettype none
// ============================================================================
// simple_dram_resp_fifo : synchronous FIFO with push/pop/full/empty/count
// Rev 1.0
// ============================================================================
module simple_dram_resp_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        wdata_i,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        rdata_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // A push into a full FIFO is still legal when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/simple_dram_responder.sv
`default_nettype none
// ============================================================================
// simple_dram_responder : SimpleDRAM channel memory model, in-order read
// responses with credit flow control. Optional SIMPLE_DRAM_RESPONDER_STATS_EN
// adds saturating read/write/stall counters.  Rev 1.0
// ============================================================================
module simple_dram_responder
  import simple_dram_responder_pkg::*;
#(
  parameter int DEPTH           = SIMPLE_DRAM_DEPTH,
  parameter int READ_LAT        = 2,
  parameter int RESP_FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
`ifdef SIMPLE_DRAM_RESPONDER_STATS_EN
  output logic [31:0] stat_reads,
  output logic [31:0] stat_writes,
  output logic [31:0] stat_stall_cycles,
`endif
  simple_dram_responder_if.slave bus
);

  localparam int DATA_W   = SIMPLE_DRAM_DATA_W;
  localparam int LINE_OFS = $clog2(SIMPLE_DRAM_LINE_BYTES);
  localparam int IDX_W    = $clog2(DEPTH);
  localparam int CNT_W    = $clog2(RESP_FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] line_q [DEPTH];
  logic [IDX_W-1:0]  line_idx;
  logic              unused_addr_bits;
  logic              req_acc, rd_acc, wr_acc;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic              push_vld;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_head;

  assign line_idx         = bus.req_in.addr[LINE_OFS +: IDX_W];
  assign unused_addr_bits = ^{bus.req_in.addr[63:LINE_OFS+IDX_W], bus.req_in.addr[LINE_OFS-1:0]};

  // Credit counts every read not yet popped; a pop frees its slot only next cycle.
  assign bus.req_grant_out = rst && (inflight_q < CNT_W'(RESP_FIFO_DEPTH));
  assign req_acc           = bus.req_in.valid && bus.req_grant_out;
  assign rd_acc            = req_acc && !bus.req_in.isWrite;
  assign wr_acc            = req_acc &&  bus.req_in.isWrite;
  assign rd_data           = line_q[line_idx];
  assign pop               = bus.resp_out.valid && bus.resp_grant_in;

  always_ff @(posedge clk) begin
    if (wr_acc) line_q[line_idx] <= bus.req_in.data;
  end

  generate
    if (READ_LAT == 1) begin : g_no_pipe
      assign push_vld  = rd_acc;
      assign push_data = rd_data;
    end else begin : g_pipe
      localparam int STAGES = READ_LAT - 1;
      logic [STAGES-1:0] vld_q;
      logic [DATA_W-1:0] data_q [STAGES];

      always_ff @(posedge clk) begin
        if (!rst) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= rd_acc;
          for (int i = 1; i < STAGES; i++) vld_q[i] <= vld_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        data_q[0] <= rd_data;
        for (int i = 1; i < STAGES; i++) data_q[i] <= data_q[i-1];
      end

      assign push_vld  = vld_q[STAGES-1];
      assign push_data = data_q[STAGES-1];
    end
  endgenerate

  always_comb begin
    inflight_d = inflight_q;
    if (rd_acc && !pop)      inflight_d = inflight_q + 1'b1;
    else if (!rd_acc && pop) inflight_d = inflight_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) inflight_q <= '0;
    else      inflight_q <= inflight_d;
  end

  simple_dram_resp_fifo #(
    .DEPTH (RESP_FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_resp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_vld),
    .wdata_i (push_data),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    bus.resp_out = '0;
    if (rst && !fifo_empty) begin
      bus.resp_out.valid = 1'b1;
      bus.resp_out.data  = fifo_head;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push_vld && fifo_full));
  a_credit_covers_fifo: assert property (@(posedge clk) disable iff (!rst) fifo_count <= inflight_q);

`ifdef SIMPLE_DRAM_RESPONDER_STATS_EN
  logic [31:0] stat_reads_q, stat_writes_q, stat_stall_q;
  logic        stall;

  assign stall = bus.req_in.valid && !bus.req_grant_out;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (rd_acc && (stat_reads_q  != '1)) stat_reads_q  <= stat_reads_q  + 1'b1;
      if (wr_acc && (stat_writes_q != '1)) stat_writes_q <= stat_writes_q + 1'b1;
      if (stall  && (stat_stall_q  != '1)) stat_stall_q  <= stat_stall_q  + 1'b1;
    end
  end

  assign stat_reads        = stat_reads_q;
  assign stat_writes       = stat_writes_q;
  assign stat_stall_cycles = stat_stall_q;
`endif

endmodule
`default_nettype wire

// File: doc/simple_dram_responder.md
Name: simple_dram_responder

Overview:
- Responder end of the per-channel SimpleDRAM request/response interface; the AMI-to-SimpleDRAM converters drive it as initiators.
- Accepts MemReq (read/write) and stores write data in an on-chip line array.
- Returns MemResp for reads, in order, after a fixed pipeline latency, with response backpressure.
- Used as the channel memory model for on-chip test builds and for simulation of the AmorphOS memory system.

Parameters:
- DEPTH, 1024, number of DATA_W-bit lines in the array (power of 2)
- READ_LAT, 2, cycles from read acceptance to response entering the response FIFO (>=1)
- RESP_FIFO_DEPTH, 8, response FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low (asserted when 0)
- req_in  in  MemReq  request: valid, isWrite, addr[63:0] (byte address), data[511:0]
- req_grant_out  out  1  request accepted this cycle when req_in.valid && req_grant_out
- resp_out  out  MemResp  response: valid, data[511:0]
- resp_grant_in  in  1  response consumed when resp_out.valid && resp_grant_in

Behaviour:
- Line index is addr[log2(64)+log2(DEPTH)-1:6]. Upper address bits are ignored, so addresses wrap modulo DEPTH*64. addr[5:0] is ignored.
- Credit rule: inflight = reads in the latency pipe + FIFO occupancy.
  - req_grant_out = rst && (inflight < RESP_FIFO_DEPTH), computed combinationally from registered state only.
  - A FIFO pop in the same cycle does not free credit until the next cycle.
- Write accepted at cycle t: array line updated at the clk edge ending cycle t. No response is generated.
- Read accepted at cycle t: array read using the line value after any write committed before t.
  - Read data travels a READ_LAT-stage valid/data shift pipe and is pushed into the FIFO at edge t+READ_LAT.
  - It is visible on resp_out at cycle t+READ_LAT at the earliest.
  - Write at t followed by read of the same line at t+1 returns the new data.
- Responses are returned strictly in acceptance order.
- resp_out.valid = FIFO not empty. resp_out.data = FIFO head, held stable until granted.
- FIFO push and pop in the same cycle are both performed; occupancy is unchanged.
- The credit rule guarantees the FIFO never overflows. An assertion flags a push when full.
- Full: req_grant_out = 0 when inflight == RESP_FIFO_DEPTH. Both reads and writes are stalled, keeping a single ordering point.
- Empty: resp_out.valid = 0 and resp_out.data = 0.
- Reset (rst == 0, at any time, including mid-operation):
  - req_grant_out = 0 and resp_out.valid = 0 from the first reset cycle.
  - Pipe valids, FIFO pointers and counters cleared; in-flight reads are dropped.
  - Array contents are not reset.
- No state machine beyond pipe and FIFO. Credit counter width is log2(RESP_FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro SIMPLE_DRAM_RESPONDER_STATS_EN.
- Defined: adds outputs stat_reads, stat_writes and stat_stall_cycles, each 32 bits.
  - Counts accepted reads, accepted writes, and cycles with req_in.valid && !req_grant_out.
  - Counters saturate at 0xFFFFFFFF and clear on reset.
- Undefined: these ports and their logic are absent. Behaviour is otherwise identical.

Decomposition:
- MemReq/MemResp typedefs and the 64-byte line size constant stay in ShellTypes.
- Add SIMPLE_DRAM_LINE_BYTES and the default DEPTH to ShellTypes.
- Sub-module: simple_dram_resp_fifo, a parameterised synchronous FIFO with push, pop, full, empty and count.

Test Plan:
- Reset then idle -> during rst = 0, req_grant_out = 0 and resp_out.valid = 0. On the first cycle after release, req_grant_out = 1 and inflight = 0.
- Write addr 0x40 data 0xA5..A5, then read 0x40 the next cycle with resp_grant_in = 1 -> resp_out.valid first at read cycle + 2 with data 0xA5..A5; no response for the write.
- Write 0x0 = X, then read addr 0x10000 with DEPTH = 1024 -> wraps to line 0 and returns X.
- resp_grant_in = 0 with back-to-back reads -> exactly 8 reads granted, then req_grant_out = 0. Raising resp_grant_in drains 8 responses in order, and grants resume one cycle after the first pop.
- Write then read to the same line with resp_grant_in toggling 1/0 -> every response holds its data while ungranted; no loss or duplication over 100 random ops checked against a scoreboard.
- Assert rst = 0 with 3 reads in flight -> no responses after reset, and a subsequent read returns the pre-reset array contents. With STATS_EN defined, all counters read 0 after reset.
